// File: rtl/regfile_scoreboard_if.sv
// ============================================================================
// regfile_scoreboard_if : issue/read/writeback bundle between decode-execute
// and the register file scoreboard.            Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]    rs1_addr_i;
  logic                 rs1_re_i;
  logic [DATA_W-1:0]    rs1_data_o;
  logic [ADDR_W-1:0]    rs2_addr_i;
  logic                 rs2_re_i;
  logic [DATA_W-1:0]    rs2_data_o;
  logic                 issue_i;
  logic                 issue_rd_we_i;
  logic [ADDR_W-1:0]    issue_rd_addr_i;
  logic                 stall_o;
  logic                 rd_we_i;
  logic [ADDR_W-1:0]    rd_addr_i;
  logic [DATA_W-1:0]    rd_data_i;
  logic [2**ADDR_W-1:0] busy_o;

  modport master (
    output rs1_addr_i, rs1_re_i, rs2_addr_i, rs2_re_i,
    output issue_i, issue_rd_we_i, issue_rd_addr_i,
    output rd_we_i, rd_addr_i, rd_data_i,
    input  rs1_data_o, rs2_data_o, stall_o, busy_o
  );

  modport slave (
    input  rs1_addr_i, rs1_re_i, rs2_addr_i, rs2_re_i,
    input  issue_i, issue_rd_we_i, issue_rd_addr_i,
    input  rd_we_i, rd_addr_i, rd_data_i,
    output rs1_data_o, rs2_data_o, stall_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : integer register file with per-register pending-write
// scoreboard, RAW/WAW issue stall and optional write-through bypass. Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BYPASS_EN = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  regfile_scoreboard_if.slave bus
);

  localparam int c_NREG   = 2**ADDR_W;
  localparam bit c_BYPASS = (BYPASS_EN != 0);

  logic [DATA_W-1:0] r_regs [c_NREG];
  logic [c_NREG-1:0] r_busy;

  logic [c_NREG-1:0] w_wb_clr;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic              w_raw1;
  logic              w_raw2;
  logic              w_waw;
  logic              w_stall;
  logic              w_accept;
  logic              w_wb_fwd1;
  logic              w_wb_fwd2;

  // A writeback landing this cycle retires the hazard only when it is also forwarded.
  always_comb begin
    w_wb_clr = '0;
    for (int r = 1; r < c_NREG; r++) begin
      w_wb_clr[r] = c_BYPASS && bus.rd_we_i && (bus.rd_addr_i == ADDR_W'(r));
    end
  end

  assign w_wb_fwd1 = c_BYPASS && bus.rd_we_i && (bus.rd_addr_i == bus.rs1_addr_i);
  assign w_wb_fwd2 = c_BYPASS && bus.rd_we_i && (bus.rd_addr_i == bus.rs2_addr_i);

  always_comb begin
    w_rs1_data = r_regs[bus.rs1_addr_i];
    if (bus.rs1_addr_i == '0) begin
      w_rs1_data = '0;
    end else if (w_wb_fwd1) begin
      w_rs1_data = bus.rd_data_i;
    end
  end

  always_comb begin
    w_rs2_data = r_regs[bus.rs2_addr_i];
    if (bus.rs2_addr_i == '0) begin
      w_rs2_data = '0;
    end else if (w_wb_fwd2) begin
      w_rs2_data = bus.rd_data_i;
    end
  end

  assign w_raw1   = bus.rs1_re_i && r_busy[bus.rs1_addr_i] && !w_wb_clr[bus.rs1_addr_i];
  assign w_raw2   = bus.rs2_re_i && r_busy[bus.rs2_addr_i] && !w_wb_clr[bus.rs2_addr_i];
  assign w_waw    = bus.issue_rd_we_i && r_busy[bus.issue_rd_addr_i]
                    && !w_wb_clr[bus.issue_rd_addr_i];
  assign w_stall  = bus.issue_i && !rst && (w_raw1 || w_raw2 || w_waw);
  assign w_accept = bus.issue_i && !rst && !w_stall;

  // Issue-set is ordered after writeback-clear so a new producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < c_NREG; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (bus.rd_we_i && (bus.rd_addr_i != '0)) begin
        r_regs[bus.rd_addr_i] <= bus.rd_data_i;
        r_busy[bus.rd_addr_i] <= 1'b0;
      end
      if (w_accept && bus.issue_rd_we_i && (bus.issue_rd_addr_i != '0)) begin
        r_busy[bus.issue_rd_addr_i] <= 1'b1;
      end
    end
  end

  assign bus.rs1_data_o = w_rs1_data;
  assign bus.rs2_data_o = w_rs2_data;
  assign bus.stall_o    = w_stall;
  assign bus.busy_o     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed vector bench for bypass and no-bypass
// builds of regfile_scoreboard.               Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] rs1_addr = '0, rs2_addr = '0, iss_rd = '0, rd_addr = '0;
  logic              rs1_re = 1'b0, rs2_re = 1'b0, issue = 1'b0, iss_we = 1'b0, rd_we = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();
  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_n ();

  assign if_b.rs1_addr_i = rs1_addr;  assign if_n.rs1_addr_i = rs1_addr;
  assign if_b.rs1_re_i   = rs1_re;    assign if_n.rs1_re_i   = rs1_re;
  assign if_b.rs2_addr_i = rs2_addr;  assign if_n.rs2_addr_i = rs2_addr;
  assign if_b.rs2_re_i   = rs2_re;    assign if_n.rs2_re_i   = rs2_re;
  assign if_b.issue_i    = issue;     assign if_n.issue_i    = issue;
  assign if_b.issue_rd_we_i   = iss_we;  assign if_n.issue_rd_we_i   = iss_we;
  assign if_b.issue_rd_addr_i = iss_rd;  assign if_n.issue_rd_addr_i = iss_rd;
  assign if_b.rd_we_i    = rd_we;     assign if_n.rd_we_i    = rd_we;
  assign if_b.rd_addr_i  = rd_addr;   assign if_n.rd_addr_i  = rd_addr;
  assign if_b.rd_data_i  = rd_data;   assign if_n.rd_data_i  = rd_data;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if_n.slave)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] exp_b1;
    logic [DATA_W-1:0] exp_b2;
    logic [DATA_W-1:0] exp_n1;
    logic [DATA_W-1:0] exp_n2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_re = 1'b0; rs2_re = 1'b0; issue = 1'b0; iss_we = 1'b0; rd_we = 1'b0;
    rs1_addr = '0; rs2_addr = '0; iss_rd = '0; rd_addr = '0; rd_data = '0;
  endtask

  initial begin
    //          we    wa     wd            ra1    ra2    b1            b2            n1            n2
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd0,  32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b1, 5'd12, 32'hCAFEF00D, 5'd0,  5'd12, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd7,  32'h00000001, 5'd7,  5'd12, 32'h00000001, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7,  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000001};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0};

    // Reset: stall must stay low even with a hazard-free issue presented.
    idle();
    rst = 1'b1; issue = 1'b1; iss_we = 1'b1; iss_rd = 5'd2;
    #1;
    chk("stall_in_rst", {63'd0, if_b.stall_o}, 64'd0);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_busy", {32'd0, if_b.busy_o}, 64'd0);
    chk("rst_stall", {63'd0, if_b.stall_o}, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = ADDR_W'(a);
      rs2_addr = ADDR_W'(31 - a);
      #1;
      chk($sformatf("rst_rs1_x%0d", a), {32'd0, if_b.rs1_data_o}, 64'd0);
      chk($sformatf("rst_rs2_x%0d", 31 - a), {32'd0, if_b.rs2_data_o}, 64'd0);
    end

    // Table: writes and reads, bypass vs. no-bypass visibility.
    for (int i = 0; i < 7; i++) begin
      idle();
      rd_we = vecs[i].we; rd_addr = vecs[i].wa; rd_data = vecs[i].wd;
      rs1_addr = vecs[i].ra1; rs2_addr = vecs[i].ra2;
      #1;
      chk($sformatf("vec%0d_b_rs1", i), {32'd0, if_b.rs1_data_o}, {32'd0, vecs[i].exp_b1});
      chk($sformatf("vec%0d_b_rs2", i), {32'd0, if_b.rs2_data_o}, {32'd0, vecs[i].exp_b2});
      chk($sformatf("vec%0d_n_rs1", i), {32'd0, if_n.rs1_data_o}, {32'd0, vecs[i].exp_n1});
      chk($sformatf("vec%0d_n_rs2", i), {32'd0, if_n.rs2_data_o}, {32'd0, vecs[i].exp_n2});
      step();
    end

    // Issue with rd=x0 never marks busy.
    idle();
    issue = 1'b1; iss_we = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_issue_stall", {63'd0, if_b.stall_o}, 64'd0);
    step();
    idle();
    #1;
    chk("x0_busy", {32'd0, if_b.busy_o}, 64'd0);

    // RAW: producer of x3, then consumer stalls until writeback arrives.
    issue = 1'b1; iss_we = 1'b1; iss_rd = 5'd3;
    #1;
    chk("raw_prod_stall", {63'd0, if_b.stall_o}, 64'd0);
    step();
    idle();
    #1;
    chk("raw_busy3", {32'd0, if_b.busy_o}, 64'h8);
    issue = 1'b1; rs2_re = 1'b1; rs2_addr = 5'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("raw_stall_c%0d", c), {63'd0, if_b.stall_o}, 64'd1);
      step();
    end
    rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5;
    #1;
    chk("raw_release_stall", {63'd0, if_b.stall_o}, 64'd0);
    chk("raw_release_fwd", {32'd0, if_b.rs2_data_o}, 64'hA5);
    chk("raw_nobyp_stall", {63'd0, if_n.stall_o}, 64'd1);
    step();
    idle();
    #1;
    chk("raw_busy_clear", {32'd0, if_b.busy_o}, 64'd0);
    chk("raw_nobyp_busy_clear", {32'd0, if_n.busy_o}, 64'd0);

    // Clear/set collision on x4: set wins, data lands.
    issue = 1'b1; iss_we = 1'b1; iss_rd = 5'd4;
    step();
    rd_we = 1'b1; rd_addr = 5'd4; rd_data = 32'd5;
    #1;
    chk("coll_stall", {63'd0, if_b.stall_o}, 64'd0);
    step();
    idle();
    rs1_addr = 5'd4;
    #1;
    chk("coll_data", {32'd0, if_b.rs1_data_o}, 64'd5);
    chk("coll_busy", {32'd0, if_b.busy_o}, 64'h10);

    // WAW on x9, then a mid-flight reset drops all pending state.
    idle();
    issue = 1'b1; iss_we = 1'b1; iss_rd = 5'd9;
    step();
    #1;
    chk("waw_stall", {63'd0, if_b.stall_o}, 64'd1);
    chk("waw_busy", {32'd0, if_b.busy_o}, 64'h210);
    rst = 1'b1;
    #1;
    chk("waw_stall_in_rst", {63'd0, if_b.stall_o}, 64'd0);
    step();
    rst = 1'b0;
    idle();
    rs1_addr = 5'd9; rs2_addr = 5'd7;
    #1;
    chk("mid_rst_busy", {32'd0, if_b.busy_o}, 64'd0);
    chk("mid_rst_x9", {32'd0, if_b.rs1_data_o}, 64'd0);
    chk("mid_rst_x7", {32'd0, if_b.rs2_data_o}, 64'd0);
    rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'h1;
    step();
    idle();
    issue = 1'b1; rs1_re = 1'b1; rs1_addr = 5'd9; iss_we = 1'b1; iss_rd = 5'd9;
    #1;
    chk("post_rst_stall", {63'd0, if_b.stall_o}, 64'd0);
    chk("post_rst_x9", {32'd0, if_b.rs1_data_o}, 64'd1);
    step();
    idle();
    #1;
    chk("self_rd_busy9", {32'd0, if_b.busy_o}, 64'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file on the far side of the execute stage's rd interface.
- Sinks the rd_we/rd_addr/rd_data writeback produced by execute.
- Sources rs1/rs2 operand data to decode/execute.
- Holds a per-register pending-write scoreboard that stalls issue on RAW/WAW hazards until the producing writeback arrives, with a same-cycle write-through bypass.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register address width (2**ADDR_W registers, index 0 hardwired zero)
BYPASS_EN, 1, 1 = same-cycle writeback forwards to read ports and clears hazard; 0 = no forwarding, writeback visible next cycle

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rs1_addr_i  in  ADDR_W  read port 1 address
rs1_re_i  in  1  instruction being issued uses rs1
rs1_data_o  out  DATA_W  read port 1 data (combinational)
rs2_addr_i  in  ADDR_W  read port 2 address
rs2_re_i  in  1  instruction being issued uses rs2
rs2_data_o  out  DATA_W  read port 2 data (combinational)
issue_i  in  1  decode presents an instruction for issue this cycle
issue_rd_we_i  in  1  issued instruction will write rd
issue_rd_addr_i  in  ADDR_W  issued instruction's rd
stall_o  out  1  issue blocked this cycle (combinational)
rd_we_i  in  1  writeback enable from execute
rd_addr_i  in  ADDR_W  writeback address
rd_data_i  in  DATA_W  writeback data
busy_o  out  2**ADDR_W  scoreboard bits, debug/observation

Behaviour:
- Reset, sampled at clk edge while rst=1:
  - All registers go to 0 and all busy bits go to 0.
  - While rst=1, stall_o=0, and writeback and issue are ignored.
  - A reset mid-operation discards all pending writes; a later writeback to a formerly busy register is an ordinary write.
- x0:
  - Reads always return 0.
  - Writes are dropped.
  - Never marked busy; never causes a hazard.
- Write, at the clk edge with rd_we_i=1 and rd_addr_i!=0:
  - reg[rd_addr_i] <= rd_data_i.
  - busy[rd_addr_i] <= 0, unless set again by a same-edge issue (see below).
  - Writeback to a non-busy register is legal and just updates data.
- Read (combinational, zero latency):
  - rsN_data_o = reg[rsN_addr_i].
  - If BYPASS_EN=1 and rd_we_i=1 and rd_addr_i==rsN_addr_i!=0: rsN_data_o = rd_data_i.
  - rsN_re_i affects hazard detection only, never data.
- Writeback clear: wb_clr[r] = rd_we_i && rd_addr_i==r && r!=0 && BYPASS_EN.
- Hazard terms:
  - raw1 = rs1_re_i && busy[rs1_addr_i] && !wb_clr[rs1_addr_i].
  - raw2 = the same for rs2.
  - waw = issue_rd_we_i && busy[issue_rd_addr_i] && !wb_clr[issue_rd_addr_i].
- stall_o = issue_i && !rst && (raw1 || raw2 || waw).
- Issue accept = issue_i && !stall_o. On accept with issue_rd_we_i=1 and issue_rd_addr_i!=0: busy[issue_rd_addr_i] <= 1.
- Simultaneous writeback-clear and issue-set on the same register at one edge: set wins, so the register stays busy for the new producer.
- Issue whose rd equals its own rs (e.g. addi x5,x5,1) with x5 not busy: accepted, reads the current value, then x5 becomes busy.
- busy_o[0] is always 0.

Test Plan:
- Reset, then read: hold rst=1 for 1 cycle → rs1_data_o=rs2_data_o=0 for every address, busy_o=0, stall_o=0.
- Write then read x0: write x0=32'hDEADBEEF → reading x0 returns 0; busy_o[0] stays 0 after an issue with rd=0.
- Write-through bypass: write x7=32'h12345678 with rs1_addr_i=7 in the same cycle → rs1_data_o=32'h12345678 that cycle (BYPASS_EN=1); with BYPASS_EN=0 it reads the old value (0), then the new value next cycle.
- RAW stall and release:
  - Issue rd=x3; next cycle issue rs2=x3 with rs2_re_i=1 → stall_o=1, held for 3 cycles.
  - Writeback x3=32'hA5 arrives → same cycle stall_o=0 and rs2_data_o=32'hA5 (bypass); busy_o[3] then 0.
- Clear/set collision: busy x4, writeback x4=5 while issuing rd=x4 with no rs hazards → accepted; after the edge reg x4=5 and busy_o[4]=1.
- WAW and reset mid-flight:
  - Busy x9 plus an issue with rd=x9 → stall_o=1.
  - Assert rst one cycle → busy_o=0, x9=0.
  - Writeback x9=32'h1 afterwards → x9=1, no stall.
